// File: rtl/receptor_mdio.sv
// rtl/receptor_mdio.sv - MDIO responder: deserialises generator frames into register-file strobes
//
// Purpose: PHY-side end of the MDIO link. Watches MDC/MDIO_OUT/MDIO_OE from the
// generator, decodes 32-bit frames (ST, OP, PHYADDR, REGADDR, TA, DATA), issues a
// one-cycle write strobe for write frames, and for read frames fetches a word
// from the register file and shifts it back on MDIO_IN.
//
// Ports:
//   clk        system clock (also the source of MDC)
//   rst        synchronous active-high reset
//   MDC        management clock, half the clk rate
//   MDIO_OUT   serial data from generator, MSB first
//   MDIO_OE    generator drive enable
//   MDIO_IN    serial read data back to generator
//   MDIO_IN_OE high while this block drives MDIO_IN
//   ADDR       {PHYADDR, REGADDR} of the current frame
//   WR_DATA    write payload
//   WR_STB     one-cycle write strobe
//   RD_STB     one-cycle read request
//   RD_DATA    register-file read data, valid while RD_STB is high
//   FRAME_ERR  one-cycle pulse on a malformed or aborted frame

module receptor_mdio #(
    parameter logic [4:0] PHY_ADDR = 5'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MDC,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    output logic        MDIO_IN,
    output logic        MDIO_IN_OE,
    output logic [9:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        RD_STB,
    input  logic [15:0] RD_DATA,
    output logic        FRAME_ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WDAT,
        S_RLOAD,
        S_RSEND,
        S_SKIP
    } state_t;

    state_t      state_q, state_d;
    logic        mdc_q;
    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] hdr_q, hdr_d;       // header, then reused for the write payload
    logic [15:0] rsh_q, rsh_d;       // read shift register; bit 15 drives MDIO_IN
    logic        rdoe_q, rdoe_d;
    logic [9:0]  addr_q, addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        wr_stb_q, wr_stb_d;
    logic        err_q, err_d;

    logic        rise;
    logic [15:0] hdr_next;
    logic [5:0]  cnt_inc;
    logic        hdr_bad;

    assign rise     = MDC & ~mdc_q;
    assign hdr_next = {hdr_q[14:0], MDIO_OUT};
    assign cnt_inc  = cnt_q + 6'd1;
    // After four bits hdr_next[3:0] holds {ST, OP}.
    assign hdr_bad  = (hdr_next[3:2] != 2'b01) ||
                      !((hdr_next[1:0] == 2'b01) || (hdr_next[1:0] == 2'b10));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mdc_q     <= 1'b0;
            cnt_q     <= 6'd0;
            hdr_q     <= 16'd0;
            rsh_q     <= 16'd0;
            rdoe_q    <= 1'b0;
            addr_q    <= 10'd0;
            wr_data_q <= 16'd0;
            wr_stb_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mdc_q     <= MDC;
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
            rsh_q     <= rsh_d;
            rdoe_q    <= rdoe_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_stb_q  <= wr_stb_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hdr_d     = hdr_q;
        rsh_d     = rsh_q;
        rdoe_d    = rdoe_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_stb_d  = 1'b0;
        err_d     = 1'b0;
        RD_STB    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise && MDIO_OE) begin
                    hdr_d   = {15'd0, MDIO_OUT};
                    cnt_d   = 6'd1;
                    state_d = S_HDR;
                end
            end

            S_HDR: begin
                if (rise) begin
                    if (!MDIO_OE) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        hdr_d = hdr_next;
                        cnt_d = cnt_inc;
                        if ((cnt_inc == 6'd4) && hdr_bad) begin
                            // Bad ST/OP: report now, but stay in step with the
                            // generator until its 32 bits are over.
                            err_d   = 1'b1;
                            state_d = S_SKIP;
                        end else if (cnt_inc == 6'd16) begin
                            addr_d = hdr_next[11:2];
                            if (hdr_next[11:7] != PHY_ADDR) begin
                                state_d = S_SKIP;
                            end else if (hdr_next[13:12] == 2'b01) begin
                                state_d = S_WDAT;
                            end else begin
                                state_d = S_RLOAD;
                            end
                        end
                    end
                end
            end

            S_WDAT: begin
                if (rise) begin
                    if (!MDIO_OE) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        hdr_d = hdr_next;
                        cnt_d = cnt_inc;
                        if (cnt_inc == 6'd32) begin
                            wr_data_d = hdr_next;
                            wr_stb_d  = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end
                end
            end

            S_RLOAD: begin
                // Falls in the MDC-low half after the last header bit, so the
                // first data bit is on MDIO_IN before the next rise.
                RD_STB  = 1'b1;
                rsh_d   = RD_DATA;
                rdoe_d  = 1'b1;
                state_d = S_RSEND;
            end

            S_RSEND: begin
                if (rise) begin
                    if (MDIO_OE) begin
                        err_d   = 1'b1;
                        rsh_d   = 16'd0;
                        rdoe_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == 6'd32) begin
                            rsh_d   = 16'd0;
                            rdoe_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            rsh_d = {rsh_q[14:0], 1'b0};
                        end
                    end
                end
            end

            S_SKIP: begin
                if (rise) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 6'd32) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign MDIO_IN    = rsh_q[15];
    assign MDIO_IN_OE = rdoe_q;
    assign ADDR       = addr_q;
    assign WR_DATA    = wr_data_q;
    assign WR_STB     = wr_stb_q;
    assign FRAME_ERR  = err_q;

endmodule

// File: tb/tb_receptor_mdio.sv
// tb/tb_receptor_mdio.sv - directed self-checking bench for receptor_mdio

module tb_receptor_mdio;

    logic        clk = 1'b0;
    logic        rst;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic        MDIO_IN;
    logic        MDIO_IN_OE;
    logic [9:0]  ADDR;
    logic [15:0] WR_DATA;
    logic        WR_STB;
    logic        RD_STB;
    logic [15:0] RD_DATA;
    logic        FRAME_ERR;

    int checks = 0;
    int errors = 0;

    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, oe_cyc = 0, overlap = 0;
    logic [9:0]  wr_addr_seen = '0, rd_addr_seen = '0;
    logic [15:0] wr_data_seen = '0;

    int          rd_snap, err_snap4, oe_rises;
    logic [15:0] rbits;

    always #5 clk = ~clk;

    receptor_mdio #(.PHY_ADDR(5'd1)) dut (
        .clk        (clk),
        .rst        (rst),
        .MDC        (MDC),
        .MDIO_OUT   (MDIO_OUT),
        .MDIO_OE    (MDIO_OE),
        .MDIO_IN    (MDIO_IN),
        .MDIO_IN_OE (MDIO_IN_OE),
        .ADDR       (ADDR),
        .WR_DATA    (WR_DATA),
        .WR_STB     (WR_STB),
        .RD_STB     (RD_STB),
        .RD_DATA    (RD_DATA),
        .FRAME_ERR  (FRAME_ERR)
    );

    always @(negedge clk) begin
        if (WR_STB) begin
            wr_cnt++;
            wr_data_seen = WR_DATA;
            wr_addr_seen = ADDR;
        end
        if (RD_STB) begin
            rd_cnt++;
            rd_addr_seen = ADDR;
        end
        if (FRAME_ERR) err_cnt++;
        if (MDIO_IN_OE) oe_cyc++;
        if ((WR_STB || RD_STB) && FRAME_ERR) overlap++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One MDC period; the generator's sample of MDIO_IN is taken while MDC is high.
    task automatic mdio_bit(input logic oe, input logic d);
        MDC = 1'b0; MDIO_OE = oe; MDIO_OUT = d;
        @(posedge clk); #1 MDC = 1'b1; #1;
        if (MDIO_IN_OE) oe_rises++;
        rbits = {rbits[14:0], MDIO_IN};
        @(posedge clk); #1 MDC = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic send(input logic [31:0] f, input int n_oe, input int nbits);
        oe_rises = 0;
        for (int i = 0; i < nbits; i++) begin
            if (i == 16) rd_snap = rd_cnt;
            mdio_bit(i < n_oe, (i < n_oe) ? f[31-i] : 1'b0);
            if (i == 3) err_snap4 = err_cnt;
        end
    endtask

    task automatic idle(input int n);
        MDC = 1'b0; MDIO_OE = 1'b0; MDIO_OUT = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int b_wr, b_rd, b_err, b_oe, e4;
        rst = 1'b1; MDC = 1'b0; MDIO_OE = 1'b0; MDIO_OUT = 1'b0;
        RD_DATA = 16'hA5C3; rbits = '0; oe_rises = 0; rd_snap = 0; err_snap4 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mdio_in", MDIO_IN, 0);
        check("rst_mdio_in_oe", MDIO_IN_OE, 0);
        check("rst_addr", ADDR, 0);
        check("rst_wr_data", WR_DATA, 0);
        check("rst_strobes", {WR_STB, RD_STB, FRAME_ERR}, 0);
        rst = 1'b0;
        idle(2);

        // write to own address
        b_wr = wr_cnt; b_err = err_cnt; b_oe = oe_cyc;
        send(32'h508EBEEF, 32, 32);
        idle(3);
        check("wr_count", wr_cnt - b_wr, 1);
        check("wr_data", wr_data_seen, 16'hBEEF);
        check("wr_addr", wr_addr_seen, 10'h023);
        check("wr_no_err", err_cnt - b_err, 0);
        check("wr_no_drive", oe_cyc - b_oe, 0);
        check("wr_data_hold", WR_DATA, 16'hBEEF);

        // read
        b_rd = rd_cnt; b_err = err_cnt;
        send(32'h608E0000, 16, 32);
        idle(3);
        check("rd_before_data", rd_snap - b_rd, 1);
        check("rd_count", rd_cnt - b_rd, 1);
        check("rd_addr", rd_addr_seen, 10'h023);
        check("rd_bits", rbits, 16'hA5C3);
        check("rd_oe_rises", oe_rises, 16);
        check("rd_no_err", err_cnt - b_err, 0);
        check("rd_release", {MDIO_IN_OE, MDIO_IN}, 0);

        // address mismatch, then a valid write
        b_wr = wr_cnt; b_rd = rd_cnt; b_err = err_cnt; b_oe = oe_cyc;
        send(32'h510EBEEF, 32, 32);
        idle(2);
        check("mis_no_wr", wr_cnt - b_wr, 0);
        check("mis_no_rd", rd_cnt - b_rd, 0);
        check("mis_no_err", err_cnt - b_err, 0);
        check("mis_no_drive", oe_cyc - b_oe, 0);
        check("mis_addr_latched", ADDR, 10'h043);
        send(32'h508E1234, 32, 32);
        idle(3);
        check("mis_next_wr", wr_cnt - b_wr, 1);
        check("mis_next_data", wr_data_seen, 16'h1234);

        // bad start, then a back-to-back valid write
        b_wr = wr_cnt; b_err = err_cnt;
        send(32'h108EBEEF, 32, 32);
        e4 = err_snap4;
        check("bad_err_at4", e4 - b_err, 1);
        check("bad_err_total", err_cnt - b_err, 1);
        check("bad_no_wr", wr_cnt - b_wr, 0);
        send(32'h508ECAFE, 32, 32);
        idle(3);
        check("b2b_wr", wr_cnt - b_wr, 1);
        check("b2b_data", wr_data_seen, 16'hCAFE);

        // abort after 20 bits
        b_wr = wr_cnt; b_err = err_cnt;
        send(32'h508EBEEF, 20, 21);
        idle(3);
        check("abort_err", err_cnt - b_err, 1);
        check("abort_no_wr", wr_cnt - b_wr, 0);
        send(32'h508E5A5A, 32, 32);
        idle(3);
        check("abort_next_wr", wr_cnt - b_wr, 1);
        check("abort_next_data", wr_data_seen, 16'h5A5A);

        // reset during read data phase
        b_err = err_cnt;
        send(32'h608E0000, 16, 24);
        check("rrst_driving", MDIO_IN_OE, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rrst_mdio_in", MDIO_IN, 0);
        check("rrst_mdio_in_oe", MDIO_IN_OE, 0);
        rst = 1'b0;
        idle(3);
        check("rrst_no_err", err_cnt - b_err, 0);
        RD_DATA = 16'h3C96;
        b_rd = rd_cnt;
        send(32'h608E0000, 16, 32);
        idle(3);
        check("rrst_next_rd", rd_cnt - b_rd, 1);
        check("rrst_next_bits", rbits, 16'h3C96);
        check("rrst_next_oe", oe_rises, 16);

        check("strobe_err_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/receptor_mdio.md
Name: receptor_mdio

Overview:
- PHY-side (responder) end of the team's MDIO link; pairs with the MDIO generator/transmitter.
- Observes MDC, MDIO_OUT and MDIO_OE from the generator and deserialises each 32-bit frame.
- Write frames become a one-cycle register-file write strobe.
- Read frames fetch a 16-bit word from the register file and shift it back serially on MDIO_IN.

Parameters:
- PHY_ADDR, 5'd1, PHY address this block answers to. Frames carrying any other address are consumed but ignored.

Ports:
- clk  input  1  system clock; same clock that generates MDC.
- rst  input  1  synchronous reset, active-high.
- MDC  input  1  management clock from generator; half the clk rate.
- MDIO_OUT  input  1  serial data from generator, MSB first.
- MDIO_OE  input  1  generator drive enable.
- MDIO_IN  output  1  serial read data to generator.
- MDIO_IN_OE  output  1  high while this block drives MDIO_IN.
- ADDR  output  10  {PHYADDR, REGADDR} of the current frame.
- WR_DATA  output  16  write payload.
- WR_STB  output  1  one-cycle write strobe.
- RD_STB  output  1  one-cycle read request.
- RD_DATA  input  16  register-file read data; combinational, valid in the cycle RD_STB is high.
- FRAME_ERR  output  1  one-cycle pulse on a malformed or aborted frame.

Behaviour:
- Reset (rst=1 at posedge clk): all outputs go to 0, FSM goes to IDLE, counters and shift registers clear. Reset mid-frame abandons the frame with no strobe and no error pulse.
- Edge detect: mdc_q <= MDC. A rise is MDC & ~mdc_q. All serial activity is keyed to rise cycles.
- Frame layout (bit 31 first):
  - [31:30] ST = 01
  - [29:28] OP: 01 = write, 10 = read
  - [27:23] PHYADDR
  - [22:18] REGADDR
  - [17:16] TA (ignored)
  - [15:0] DATA
- Bit counter: 6 bits, counts sampled bits 1..32.
- IDLE: on a rise with MDIO_OE=1, sample MDIO_OUT as bit 31, set counter to 1, go to HDR.
- HDR: on each rise, shift MDIO_OUT into the header register.
  - After bit 4: if ST≠01 or OP∉{01,10}, pulse FRAME_ERR and go to SKIP.
  - If MDIO_OE=0 on any HDR rise, pulse FRAME_ERR and go to IDLE.
  - After bit 16, latch ADDR. PHYADDR≠PHY_ADDR → SKIP (no error). Else OP=01 → WDAT, OP=10 → RLOAD.
- WDAT: sample 16 bits on rises with MDIO_OE=1.
  - On the 32nd bit's rise cycle, register WR_DATA and set WR_STB=1 for exactly the next clk cycle, then go to IDLE.
  - If MDIO_OE=0 during WDAT, pulse FRAME_ERR, no WR_STB, go to IDLE.
- RLOAD (one clk cycle): RD_STB=1 with ADDR valid; capture RD_DATA into a 16-bit shift register.
  - Set MDIO_IN = RD_DATA[15] and MDIO_IN_OE=1 at the end of this cycle, then go to RSEND.
  - First MDIO_IN bit is stable before the first data-phase rise.
- RSEND: on each rise, the generator samples the current bit. On the following clk edge, shift left and present the next bit.
  - After the 16th rise (frame bit 32): clear MDIO_IN and MDIO_IN_OE, go to IDLE.
  - MDIO_OE=1 seen on a rise in RSEND is a bus conflict: pulse FRAME_ERR, release the bus, go to IDLE.
- SKIP: count rises regardless of MDIO_OE until 32 total, then go to IDLE. No strobes, MDIO_IN_OE stays 0.
- Back-to-back frames: a rise with MDIO_OE=1 on the first cycle after returning to IDLE starts a new frame.
- Simultaneous events: rst overrides everything. WR_STB/RD_STB and FRAME_ERR are never high together.
- Widths: ADDR = {PHYADDR[4:0], REGADDR[4:0]}. WR_DATA and ADDR hold their values until the next frame overwrites them.

Test Plan:
- Write, PHY_ADDR=1: send 0x508EBEEF (OE high 32 MDC) → exactly one WR_STB, ADDR=0x023, WR_DATA=0xBEEF, FRAME_ERR=0, MDIO_IN_OE=0 throughout.
- Read: send header 0x608E with OE high 16 MDC then low 16, RD_DATA=0xA5C3 → one RD_STB with ADDR=0x023; MDIO_IN_OE high 16 rises; bits sampled on rises = 1010010111000011; RD_STB precedes the first data rise.
- Address mismatch: send 0x510EBEEF → no WR_STB/RD_STB/FRAME_ERR; a following valid write 0x508E1234 yields WR_DATA=0x1234.
- Bad start: send 0x108EBEEF (ST=00) → FRAME_ERR pulse after the 4th rise, no WR_STB; block returns to IDLE after 32 rises; the next valid frame is accepted.
- Abort: drop MDIO_OE after 20 bits of a write frame → FRAME_ERR pulse, no WR_STB, IDLE.
- Reset mid-read: assert rst during RSEND bit 8 → MDIO_IN=0, MDIO_IN_OE=0 the next cycle, no FRAME_ERR; a subsequent read completes normally.
